// File: rtl/xlr8_pmem_pkg.sv
// ---------------------------------------------------------------------------
// xlr8_pmem_pkg
// Shared definitions for the program memory and its page write engine.
//   pmem_pgwr_state_e : page write FSM states (IDLE, PROG, DONE)
//   PM_ERASED         : erased flash word value (all-ones), sliced to DATA_W
//   pm_phys_addr()    : logical-to-physical word address folding
// ---------------------------------------------------------------------------
package xlr8_pmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PROG = 2'd1,
        DONE = 2'd2
    } pmem_pgwr_state_e;

    localparam logic [255:0] PM_ERASED = '1;

    // Folds a 16-bit logical word address onto a smaller physical array.
    // Bits below pa_w pass through; the top physical bit is set whenever any
    // logical bit from pa_w-1 up to la_w-1 is set, so every address above the
    // physical size aliases into the upper half. Bits at la_w and above are
    // ignored. With la_w == pa_w this is the identity on the low la_w bits.
    function automatic logic [15:0] pm_phys_addr(input logic [15:0] addr,
                                                 input int          la_w,
                                                 input int          pa_w);
        logic [15:0] lo_mask;
        logic [15:0] hi_mask;
        logic [15:0] top_bit;
        lo_mask = (16'h1 << pa_w) - 16'h1;
        hi_mask = ((16'h1 << la_w) - 16'h1) & ~((16'h1 << (pa_w - 1)) - 16'h1);
        top_bit = 16'h1 << (pa_w - 1);
        return (addr & lo_mask) | (((addr & hi_mask) != 16'h0) ? top_bit : 16'h0);
    endfunction

endpackage

// File: rtl/xlr8_pmem_pgbuf.sv
// ---------------------------------------------------------------------------
// xlr8_pmem_pgbuf
// Page buffer: PAGE_WORDS x DATA_W registers collecting words for a commit.
//   clk, rst  : clock, asynchronous active-high reset (buffer -> erased)
//   i_we      : write i_wdata into slot i_waddr
//   i_clr     : synchronous clear of every slot to erased (wins over i_we)
//   i_raddr   : combinational read index
//   o_rdata   : word in slot i_raddr
// ---------------------------------------------------------------------------
module xlr8_pmem_pgbuf
    import xlr8_pmem_pkg::*;
#(
    parameter int PAGE_WORDS = 64,
    parameter int DATA_W     = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_we,
    input  logic [$clog2(PAGE_WORDS)-1:0] i_waddr,
    input  logic [DATA_W-1:0]             i_wdata,
    input  logic                          i_clr,
    input  logic [$clog2(PAGE_WORDS)-1:0] i_raddr,
    output logic [DATA_W-1:0]             o_rdata
);

    logic [DATA_W-1:0] r_buf [PAGE_WORDS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf <= '{default: PM_ERASED[DATA_W-1:0]};
        end else if (i_clr) begin
            r_buf <= '{default: PM_ERASED[DATA_W-1:0]};
        end else if (i_we) begin
            r_buf[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_buf[i_raddr];

endmodule

// File: rtl/xlr8_pmem_pgwr.sv
// ---------------------------------------------------------------------------
// xlr8_pmem_pgwr
// Dual-port AVR program memory with a page-buffer write engine.
//   clk, rst_flash    : clock, asynchronous active-high reset
//   pm_core_rd_addr   : instruction fetch address (port B)
//   pm_core_rd_data   : fetched word, 1-cycle latency, write-first forwarding
//   pm_ce, pm_wr      : direct access on port A (write / read), idle only
//   pm_addr           : direct, page-load slot and commit address
//   pm_wr_data        : direct write data and page-load data
//   pm_rd_data        : direct read data, holds between reads
//   spm_ld            : load pm_wr_data into buffer slot pm_addr[PG_W-1:0]
//   spm_commit        : program the buffer into the page containing pm_addr
//   spm_busy          : commit in progress (PAGE_WORDS+1 cycles)
//   spm_done          : one-cycle pulse at the end of a commit
// ---------------------------------------------------------------------------
module xlr8_pmem_pgwr
    import xlr8_pmem_pkg::*;
#(
    parameter int PM_SIZE      = 16,
    parameter int PM_REAL_SIZE = PM_SIZE,
    parameter int PAGE_WORDS   = 64,
    parameter int DATA_W       = 16
) (
    input  logic              clk,
    input  logic              rst_flash,
    input  logic [15:0]       pm_core_rd_addr,
    output logic [DATA_W-1:0] pm_core_rd_data,
    input  logic              pm_ce,
    input  logic              pm_wr,
    input  logic [15:0]       pm_addr,
    input  logic [DATA_W-1:0] pm_wr_data,
    output logic [DATA_W-1:0] pm_rd_data,
    input  logic              spm_ld,
    input  logic              spm_commit,
    output logic              spm_busy,
    output logic              spm_done
);

    localparam int PG_W      = $clog2(PAGE_WORDS);
    localparam int LA_W      = $clog2(PM_SIZE * 1024);
    localparam int PA_W      = $clog2(PM_REAL_SIZE * 1024);
    localparam int PN_W      = PA_W - PG_W;
    localparam int MEM_DEPTH = 1 << PA_W;

    pmem_pgwr_state_e  r_state;
    logic [PG_W-1:0]   r_idx;
    logic [PN_W-1:0]   r_page;
    logic [DATA_W-1:0] r_mem [MEM_DEPTH];
    logic [DATA_W-1:0] r_core_rd;
    logic [DATA_W-1:0] r_rd;

    logic [PA_W-1:0]   w_a_phys;
    logic [PA_W-1:0]   w_b_phys;
    logic [PA_W-1:0]   w_a_addr;
    logic [DATA_W-1:0] w_a_wdata;
    logic [DATA_W-1:0] w_buf_rd;
    logic              w_idle;
    logic              w_prog;
    logic              w_a_we;
    logic              w_a_re;
    logic              w_ld;
    logic              w_clr;
    logic              w_last;

    assign w_a_phys = PA_W'(pm_phys_addr(pm_addr, LA_W, PA_W));
    assign w_b_phys = PA_W'(pm_phys_addr(pm_core_rd_addr, LA_W, PA_W));

    assign w_idle = (r_state == IDLE);
    assign w_prog = (r_state == PROG);
    assign w_clr  = (r_state == DONE);
    assign w_last = (r_idx == PG_W'(PAGE_WORDS - 1));

    // Outside IDLE every external port-A request and buffer load is dropped.
    assign w_a_we = w_prog | (w_idle & pm_ce & pm_wr);
    assign w_a_re = w_idle & pm_ce & ~pm_wr;
    assign w_ld   = w_idle & spm_ld;

    // Port A is owned by the commit engine while programming.
    assign w_a_addr  = w_prog ? {r_page, r_idx} : w_a_phys;
    assign w_a_wdata = w_prog ? w_buf_rd : pm_wr_data;

    xlr8_pmem_pgbuf #(
        .PAGE_WORDS (PAGE_WORDS),
        .DATA_W     (DATA_W)
    ) u_pgbuf (
        .clk     (clk),
        .rst     (rst_flash),
        .i_we    (w_ld),
        .i_waddr (pm_addr[PG_W-1:0]),
        .i_wdata (pm_wr_data),
        .i_clr   (w_clr),
        .i_raddr (r_idx),
        .o_rdata (w_buf_rd)
    );

    // A load in the commit cycle reaches the buffer at the same edge the FSM
    // enters PROG, so slot reads during PROG already see it.
    always_ff @(posedge clk or posedge rst_flash) begin
        if (rst_flash) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_page  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (spm_commit) begin
                        r_state <= PROG;
                        r_idx   <= '0;
                        r_page  <= w_a_phys[PA_W-1:PG_W];
                    end
                end
                PROG: begin
                    r_idx <= r_idx + PG_W'(1);
                    if (w_last) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Memory array: behavioural dual-port RAM, contents survive reset.
    always_ff @(posedge clk) begin
        if (w_a_we) begin
            r_mem[w_a_addr] <= w_a_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst_flash) begin
        if (rst_flash) begin
            r_rd <= '0;
        end else if (w_a_re) begin
            r_rd <= r_mem[w_a_addr];
        end
    end

    // Fetch returns the word being written on port A in the same cycle.
    always_ff @(posedge clk or posedge rst_flash) begin
        if (rst_flash) begin
            r_core_rd <= '0;
        end else if (w_a_we && (w_a_addr == w_b_phys)) begin
            r_core_rd <= w_a_wdata;
        end else begin
            r_core_rd <= r_mem[w_b_phys];
        end
    end

    assign pm_core_rd_data = r_core_rd;
    assign pm_rd_data      = r_rd;
    assign spm_busy        = ~w_idle;
    assign spm_done        = w_clr;

endmodule

// File: tb/tb_xlr8_pmem_pgwr.sv
// ---------------------------------------------------------------------------
// tb_xlr8_pmem_pgwr
// Directed bench for xlr8_pmem_pgwr. Two instances share stimulus: one with
// full physical depth and one with PM_REAL_SIZE=8 for address aliasing.
// Read and fetch requests push their expected word into queues; a monitor
// pops and compares on the cycle the DUT presents the registered result.
// ---------------------------------------------------------------------------
module tb_xlr8_pmem_pgwr;

    logic        clk = 1'b0;
    logic        rst_flash;
    logic [15:0] pm_core_rd_addr;
    logic        pm_ce;
    logic        pm_wr;
    logic [15:0] pm_addr;
    logic [15:0] pm_wr_data;
    logic        spm_ld;
    logic        spm_commit;

    logic [15:0] core_rd;
    logic [15:0] rd;
    logic        busy;
    logic        done;
    logic [15:0] al_core_rd;
    logic [15:0] al_rd;
    logic        al_busy;
    logic        al_done;

    always #5 clk = ~clk;

    xlr8_pmem_pgwr #(
        .PM_SIZE(16), .PM_REAL_SIZE(16), .PAGE_WORDS(64), .DATA_W(16)
    ) dut (
        .clk             (clk),
        .rst_flash       (rst_flash),
        .pm_core_rd_addr (pm_core_rd_addr),
        .pm_core_rd_data (core_rd),
        .pm_ce           (pm_ce),
        .pm_wr           (pm_wr),
        .pm_addr         (pm_addr),
        .pm_wr_data      (pm_wr_data),
        .pm_rd_data      (rd),
        .spm_ld          (spm_ld),
        .spm_commit      (spm_commit),
        .spm_busy        (busy),
        .spm_done        (done)
    );

    xlr8_pmem_pgwr #(
        .PM_SIZE(16), .PM_REAL_SIZE(8), .PAGE_WORDS(64), .DATA_W(16)
    ) dut_al (
        .clk             (clk),
        .rst_flash       (rst_flash),
        .pm_core_rd_addr (pm_core_rd_addr),
        .pm_core_rd_data (al_core_rd),
        .pm_ce           (pm_ce),
        .pm_wr           (pm_wr),
        .pm_addr         (pm_addr),
        .pm_wr_data      (pm_wr_data),
        .pm_rd_data      (al_rd),
        .spm_ld          (spm_ld),
        .spm_commit      (spm_commit),
        .spm_busy        (al_busy),
        .spm_done        (al_done)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] q_rd[$];
    logic [15:0] q_fe[$];
    logic        tb_rd_req = 1'b0;
    logic        tb_rd_tgt = 1'b0;
    logic        tb_fe_req = 1'b0;
    logic        tb_fe_tgt = 1'b0;
    logic        rd_chk = 1'b0;
    logic        rd_tgt_q = 1'b0;
    logic        fe_chk = 1'b0;
    logic        fe_tgt_q = 1'b0;
    logic [15:0] e_rd;
    logic [15:0] e_fe;
    int          busy_cnt = 0;
    int          done_cnt = 0;
    logic        cnt_en = 1'b0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // ---------------- monitor ----------------
    always @(posedge clk) begin
        rd_chk   <= tb_rd_req;
        rd_tgt_q <= tb_rd_tgt;
        fe_chk   <= tb_fe_req;
        fe_tgt_q <= tb_fe_tgt;
    end

    always @(negedge clk) begin
        if (rd_chk) begin
            if (q_rd.size() == 0) begin
                chk("rd_queue_underflow", 32'd1, 32'd0);
            end else begin
                e_rd = q_rd.pop_front();
                chk(rd_tgt_q ? "al_rd" : "pm_rd", rd_tgt_q ? al_rd : rd, e_rd);
            end
        end
        if (fe_chk) begin
            if (q_fe.size() == 0) begin
                chk("fe_queue_underflow", 32'd1, 32'd0);
            end else begin
                e_fe = q_fe.pop_front();
                chk(fe_tgt_q ? "al_fe" : "pm_fe", fe_tgt_q ? al_core_rd : core_rd, e_fe);
            end
        end
        if (cnt_en) begin
            if (busy) busy_cnt++;
            if (done) done_cnt++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        pm_ce = 1'b1; pm_wr = 1'b1; pm_addr = a; pm_wr_data = d;
        tick();
        pm_ce = 1'b0; pm_wr = 1'b0;
    endtask

    task automatic rd_exp(input logic [15:0] a, input logic [15:0] e, input logic tgt);
        pm_ce = 1'b1; pm_wr = 1'b0; pm_addr = a;
        tb_rd_req = 1'b1; tb_rd_tgt = tgt;
        q_rd.push_back(e);
        tick();
        pm_ce = 1'b0; tb_rd_req = 1'b0;
    endtask

    task automatic fetch_exp(input logic [15:0] a, input logic [15:0] e, input logic tgt);
        pm_core_rd_addr = a;
        tb_fe_req = 1'b1; tb_fe_tgt = tgt;
        q_fe.push_back(e);
        tick();
        tb_fe_req = 1'b0;
    endtask

    task automatic ld(input logic [15:0] slot, input logic [15:0] d);
        spm_ld = 1'b1; pm_addr = slot; pm_wr_data = d;
        tick();
        spm_ld = 1'b0;
    endtask

    task automatic commit(input logic [15:0] a);
        pm_addr = a; spm_commit = 1'b1;
        tick();
        spm_commit = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (busy && n < 300) begin
            tick();
            n++;
        end
        chk(nm, {31'd0, busy}, 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst_flash = 1'b1;
        pm_core_rd_addr = 16'h0000;
        pm_ce = 1'b0; pm_wr = 1'b0; pm_addr = 16'h0000; pm_wr_data = 16'h0000;
        spm_ld = 1'b0; spm_commit = 1'b0;
        #2;
        chk("reset_core_rd", {16'd0, core_rd}, 32'd0);
        chk("reset_pm_rd",   {16'd0, rd}, 32'd0);
        chk("reset_busy",    {31'd0, busy}, 32'd0);
        chk("reset_done",    {31'd0, done}, 32'd0);
        tick();
        tick();
        rst_flash = 1'b0;

        // Direct write/read and fetch, plus same-cycle forwarding.
        wr(16'h0010, 16'hABCD);
        rd_exp(16'h0010, 16'hABCD, 1'b0);
        fetch_exp(16'h0010, 16'hABCD, 1'b0);
        pm_core_rd_addr = 16'h0020; tb_fe_req = 1'b1; tb_fe_tgt = 1'b0;
        q_fe.push_back(16'h1234);
        wr(16'h0020, 16'h1234);
        tb_fe_req = 1'b0;

        // Known background values around the pages under test.
        wr(16'h007F, 16'hAAAA);
        wr(16'h00C0, 16'hBBBB);
        wr(16'h0200, 16'h0F0F);
        wr(16'h0100, 16'h1111);
        wr(16'h013F, 16'h2222);
        wr(16'h040A, 16'h4444);
        wr(16'h040B, 16'h4445);
        wr(16'h0005, 16'h9999);

        // Full page commit with busy-time rejection and forwarding.
        for (int i = 0; i < 64; i++) ld(16'(i), 16'h1000 + 16'(i));
        busy_cnt = 0; done_cnt = 0; cnt_en = 1'b1;
        commit(16'h0085);
        for (int k = 0; k < 200 && busy; k++) begin
            if (k == 5) begin
                pm_ce = 1'b1; pm_wr = 1'b1; pm_addr = 16'h0200; pm_wr_data = 16'h5555;
                spm_ld = 1'b1; spm_commit = 1'b1;
            end
            if (k == 7) begin
                pm_core_rd_addr = 16'h0087; tb_fe_req = 1'b1; tb_fe_tgt = 1'b0;
                q_fe.push_back(16'h1007);
            end
            if (k == 9) begin
                pm_ce = 1'b1; pm_wr = 1'b0; pm_addr = 16'h007F;
            end
            tick();
            pm_ce = 1'b0; pm_wr = 1'b0; spm_ld = 1'b0; spm_commit = 1'b0; tb_fe_req = 1'b0;
        end
        cnt_en = 1'b0;
        chk("busy_cycles", busy_cnt, 32'd65);
        chk("done_pulses", done_cnt, 32'd1);
        chk("rd_hold_busy", {16'd0, rd}, 32'h0000ABCD);
        for (int i = 0; i < 64; i++) rd_exp(16'h0080 + 16'(i), 16'h1000 + 16'(i), 1'b0);
        rd_exp(16'h007F, 16'hAAAA, 1'b0);
        rd_exp(16'h00C0, 16'hBBBB, 1'b0);
        rd_exp(16'h0200, 16'h0F0F, 1'b0);

        // Second commit with an untouched buffer programs erased words.
        commit(16'h0100);
        wait_idle("commit2_idle");
        rd_exp(16'h0100, 16'hFFFF, 1'b0);
        rd_exp(16'h0101, 16'hFFFF, 1'b0);
        rd_exp(16'h013F, 16'hFFFF, 1'b0);

        // Load and commit in the same cycle.
        pm_addr = 16'h0303; pm_wr_data = 16'h7777; spm_ld = 1'b1; spm_commit = 1'b1;
        tick();
        spm_ld = 1'b0; spm_commit = 1'b0;
        wait_idle("ldcommit_idle");
        rd_exp(16'h0303, 16'h7777, 1'b0);
        rd_exp(16'h0302, 16'hFFFF, 1'b0);
        rd_exp(16'h0300, 16'hFFFF, 1'b0);

        // Reset after ten programmed words.
        for (int i = 0; i < 16; i++) ld(16'(i), 16'h3000 + 16'(i));
        commit(16'h0400);
        repeat (10) tick();
        rst_flash = 1'b1;
        #1;
        chk("midrst_busy",    {31'd0, busy}, 32'd0);
        chk("midrst_done",    {31'd0, done}, 32'd0);
        chk("midrst_pm_rd",   {16'd0, rd}, 32'd0);
        chk("midrst_core_rd", {16'd0, core_rd}, 32'd0);
        #1;
        rst_flash = 1'b0;
        for (int i = 0; i < 10; i++) rd_exp(16'h0400 + 16'(i), 16'h3000 + 16'(i), 1'b0);
        rd_exp(16'h040A, 16'h4444, 1'b0);
        rd_exp(16'h040B, 16'h4445, 1'b0);
        commit(16'h0400);
        wait_idle("postrst_idle");
        rd_exp(16'h0400, 16'hFFFF, 1'b0);
        rd_exp(16'h040A, 16'hFFFF, 1'b0);

        // Aliasing on the half-depth instance.
        wr(16'h1005, 16'h2222);
        rd_exp(16'h1005, 16'h2222, 1'b1);
        rd_exp(16'h2005, 16'h2222, 1'b1);
        rd_exp(16'h3005, 16'h2222, 1'b1);
        rd_exp(16'h5005, 16'h2222, 1'b1);
        rd_exp(16'h0005, 16'h9999, 1'b1);
        fetch_exp(16'h3005, 16'h2222, 1'b1);

        repeat (3) tick();
        chk("rd_queue_left", q_rd.size(), 32'd0);
        chk("fe_queue_left", q_fe.size(), 32'd0);
        chk("al_idle", {30'd0, al_busy, al_done}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
